// File: rtl/riscv_trace_buffer_pkg.sv
// Shared types and constants for the commit-trace buffer.
// Field widths here match the default parameterisation of riscv_trace_buffer.
package riscv_trace_pkg;

  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_ADDR_W = 9;
  localparam int TRACE_TS_W   = 16;
  localparam int FLAGS_W      = 3;
  localparam int REGNUM_W     = 5;

  localparam int FLG_REG = 0;
  localparam int FLG_RD  = 1;
  localparam int FLG_WR  = 2;

  typedef struct packed {
    logic [TRACE_TS_W-1:0]   ts;
    logic [FLAGS_W-1:0]      flags;
    logic [REGNUM_W-1:0]     reg_num;
    logic [TRACE_DATA_W-1:0] reg_data;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] mem_data;
  } trace_entry_t;

  // Packed entry width for an arbitrary parameterisation; field order as trace_entry_t.
  function automatic int trace_entry_w(input int data_w, input int addr_w, input int ts_w);
    return ts_w + FLAGS_W + REGNUM_W + data_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/riscv_trace_buffer_if.sv
// Capture, configuration and drain signals of the trace buffer.
// The master side is the core/host environment, the slave side is the buffer.
interface riscv_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              reg_write_sig;
  logic [4:0]        reg_num;
  logic [DATA_W-1:0] reg_data;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              halted;
  logic [1:0]        cfg_en;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [TS_W-1:0]   out_ts;
  logic [2:0]        out_flags;
  logic [4:0]        out_reg_num;
  logic [DATA_W-1:0] out_reg_data;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_mem_data;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic              frozen;

  modport master (
    output reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data,
    output halted, cfg_en, clear, out_ready,
    input  out_valid, out_ts, out_flags, out_reg_num, out_reg_data, out_addr,
    input  out_mem_data, count, overflow, drop_cnt, frozen
  );

  modport slave (
    input  reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data,
    input  halted, cfg_en, clear, out_ready,
    output out_valid, out_ts, out_flags, out_reg_num, out_reg_data, out_addr,
    output out_mem_data, count, overflow, drop_cnt, frozen
  );

endinterface

// File: rtl/riscv_trace_buffer_fifo.sv
// Power-of-two FIFO with wrap-bit pointers; clr has priority over push/pop.
// A push while full is only accepted when a pop frees the head in the same cycle.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok_s, pop_ok_s;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count     = wr_q - rd_q;
  assign dout      = mem_q[rd_q[AW-1:0]];
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok_s) wr_d = wr_q + (AW+1)'(1);
      else           wr_d = wr_q;
      if (pop_ok_s)  rd_d = rd_q + (AW+1)'(1);
      else           rd_d = rd_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read out.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clr) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture: qualifies register/memory events, timestamps them and
// buffers them in trace_fifo; capture freezes on HALT until clear.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  riscv_trace_buffer_if.slave bus
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = trace_entry_w(DATA_W, ADDR_W, TS_W);

  logic [TS_W-1:0]    ts_q, ts_d;
  logic               frozen_q, frozen_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  logic               reg_ev_s, mem_ev_s, push_s, pop_s, drop_s;
  logic [FLAGS_W-1:0] flags_s;
  logic [4:0]         reg_num_s;
  logic [DATA_W-1:0]  reg_data_s, mem_data_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [ENTRY_W-1:0] entry_s, fifo_dout_s, head_s;
  logic               fifo_empty_s, fifo_full_s;
  logic [CNT_W-1:0]   fifo_count_s;

  // Build the entry for this cycle; unqualified fields are stored as zero.
  always_comb begin
    reg_ev_s         = bus.reg_write_sig & bus.cfg_en[0];
    mem_ev_s         = (bus.wr | bus.rd) & bus.cfg_en[1];
    push_s           = (reg_ev_s | mem_ev_s) & ~frozen_q & ~bus.clear;
    flags_s          = '0;
    flags_s[FLG_REG] = reg_ev_s;
    flags_s[FLG_RD]  = bus.rd & bus.cfg_en[1];
    flags_s[FLG_WR]  = bus.wr & bus.cfg_en[1];
    reg_num_s        = '0;
    reg_data_s       = '0;
    addr_s           = '0;
    mem_data_s       = '0;
    if (reg_ev_s) begin
      reg_num_s  = bus.reg_num;
      reg_data_s = bus.reg_data;
    end else begin
      reg_num_s  = '0;
      reg_data_s = '0;
    end
    if (mem_ev_s) begin
      addr_s = bus.addr;
      if (bus.wr) mem_data_s = bus.wr_data;
      else        mem_data_s = bus.rd_data;
    end else begin
      addr_s     = '0;
      mem_data_s = '0;
    end
    entry_s = {ts_q, flags_s, reg_num_s, reg_data_s, addr_s, mem_data_s};
  end

  assign pop_s  = ~fifo_empty_s & bus.out_ready;
  assign drop_s = push_s & fifo_full_s & ~pop_s;

  trace_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear),
    .push  (push_s),
    .pop   (pop_s),
    .din   (entry_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  // Timestamp, freeze and drop bookkeeping; clear wins over everything.
  always_comb begin
    ts_d       = ts_q;
    frozen_d   = frozen_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.clear) begin
      ts_d       = '0;
      frozen_d   = 1'b0;
      overflow_d = 1'b0;
      drop_cnt_d = 16'h0000;
    end else begin
      if (!frozen_q) ts_d = ts_q + TS_W'(1);
      else           ts_d = ts_q;
      if (bus.halted) frozen_d = 1'b1;
      else            frozen_d = frozen_q;
      if (drop_s) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'h0001;
        else                        drop_cnt_d = drop_cnt_q;
      end else begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      frozen_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'h0000;
    end else begin
      ts_q       <= ts_d;
      frozen_q   <= frozen_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign head_s        = fifo_empty_s ? '0 : fifo_dout_s;
  assign bus.out_valid = ~fifo_empty_s;
  assign {bus.out_ts, bus.out_flags, bus.out_reg_num, bus.out_reg_data,
          bus.out_addr, bus.out_mem_data} = head_s;
  assign bus.count     = fifo_count_s;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.frozen    = frozen_q;

endmodule
